// File: rtl/data_mux_n.sv
// Strobe-latched N:1 data mux: direct or round-robin channel capture, sticky selector error, capture counter.
// Capture at the lock rising edge (+2 cycles with DATA_MUX_N_SYNC_EN); no backpressure, framer reads on data_valid.
module data_mux_n #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 8,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      data_lock,
    input  logic                      scan_en,
    input  logic [SEL_W-1:0]          selector,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic                      err_clr,
    output logic [WIDTH-1:0]          data_out,
    output logic [SEL_W-1:0]          ch_out,
    output logic                      data_valid,
    output logic                      sel_err,
    output logic                      err_sticky,
    output logic [CNT_W-1:0]          lock_cnt
);

    // One extra bit so CHANNELS == 2**SEL_W still compares correctly.
    localparam logic [SEL_W:0]   CH_LIM   = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(CHANNELS - 1);

    logic             lock_s;
    logic             lock_d;
    logic             lock_rise;
    logic             sel_ok;
    logic             set_err;
    logic [SEL_W-1:0] ptr;
    logic [WIDTH-1:0] sel_word;
    logic [WIDTH-1:0] ptr_word;

`ifdef DATA_MUX_N_SYNC_EN
    logic sync_q1;
    logic sync_q2;

    // Both stages reset high so a strobe held through reset is not seen as an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= data_lock;
            sync_q2 <= sync_q1;
        end
    end

    assign lock_s = sync_q2;
`else
    assign lock_s = data_lock;
`endif

    assign lock_rise = lock_s & ~lock_d;
    assign sel_ok    = {1'b0, selector} < CH_LIM;
    assign set_err   = lock_rise & ~scan_en & ~sel_ok;

    always_comb begin
        sel_word = '0;
        ptr_word = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (selector == SEL_W'(k)) sel_word = data_in[k*WIDTH +: WIDTH];
            if (ptr == SEL_W'(k))      ptr_word = data_in[k*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_d     <= 1'b1;
            data_out   <= '0;
            ch_out     <= '0;
            data_valid <= 1'b0;
            sel_err    <= 1'b0;
            err_sticky <= 1'b0;
            lock_cnt   <= '0;
            ptr        <= '0;
        end else begin
            lock_d     <= lock_s;
            data_valid <= 1'b0;
            sel_err    <= 1'b0;

            if (lock_rise) begin
                if (scan_en) begin
                    data_out   <= ptr_word;
                    ch_out     <= ptr;
                    data_valid <= 1'b1;
                    lock_cnt   <= lock_cnt + CNT_W'(1);
                end else if (sel_ok) begin
                    data_out   <= sel_word;
                    ch_out     <= selector;
                    data_valid <= 1'b1;
                    lock_cnt   <= lock_cnt + CNT_W'(1);
                end else begin
                    sel_err    <= 1'b1;
                end
            end

            // A new error outranks a simultaneous clear.
            if (set_err)
                err_sticky <= 1'b1;
            else if (err_clr)
                err_sticky <= 1'b0;

            // Pointer parks at channel 0 whenever direct mode is selected.
            if (!scan_en)
                ptr <= '0;
            else if (lock_rise)
                ptr <= (ptr == PTR_LAST) ? '0 : ptr + SEL_W'(1);
        end
    end

endmodule

// File: tb/tb_data_mux_n.sv
// Bench for data_mux_n: directed vector table, corner sequences and randomized run against a reference model.
module tb_data_mux_n;

    localparam int WIDTH    = 16;
    localparam int CHANNELS = 4;
    localparam int SEL_W    = 8;
    localparam int CNT_W    = 4;
`ifdef DATA_MUX_N_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic                      clk;
    logic                      reset;
    logic                      data_lock;
    logic                      scan_en;
    logic [SEL_W-1:0]          selector;
    logic [CHANNELS*WIDTH-1:0] data_in;
    logic                      err_clr;
    logic [WIDTH-1:0]          data_out;
    logic [SEL_W-1:0]          ch_out;
    logic                      data_valid;
    logic                      sel_err;
    logic                      err_sticky;
    logic [CNT_W-1:0]          lock_cnt;

    data_mux_n #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .data_lock(data_lock), .scan_en(scan_en),
        .selector(selector), .data_in(data_in), .err_clr(err_clr),
        .data_out(data_out), .ch_out(ch_out), .data_valid(data_valid),
        .sel_err(sel_err), .err_sticky(err_sticky), .lock_cnt(lock_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: strobe sample history, scan position and output state.
    logic [WIDTH-1:0] m_data;
    logic [SEL_W-1:0] m_ch;
    bit               m_v, m_e, m_s;
    int               m_cnt, m_ptr;
    bit               lh [4];

    function automatic void model_reset();
        m_data = '0; m_ch = '0; m_v = 0; m_e = 0; m_s = 0; m_cnt = 0; m_ptr = 0;
        for (int i = 0; i < 4; i++) lh[i] = 1'b1;
    endfunction

    function automatic void model_step();
        bit rise;
        if (reset) begin
            model_reset();
            return;
        end
        for (int i = 3; i > 0; i--) lh[i] = lh[i-1];
        lh[0] = data_lock;
        rise = lh[LAT] && !lh[LAT+1];
        m_v = 0;
        m_e = 0;
        if (rise && scan_en) begin
            m_data = data_in[m_ptr*WIDTH +: WIDTH];
            m_ch   = SEL_W'(m_ptr);
            m_v    = 1;
            m_cnt  = (m_cnt + 1) % (1 << CNT_W);
            m_ptr  = (m_ptr + 1) % CHANNELS;
        end else if (rise) begin
            if (int'(selector) < CHANNELS) begin
                m_data = data_in[int'(selector)*WIDTH +: WIDTH];
                m_ch   = selector;
                m_v    = 1;
                m_cnt  = (m_cnt + 1) % (1 << CNT_W);
            end else begin
                m_e = 1;
                m_s = 1;
            end
        end
        if (!m_e && err_clr) m_s = 0;
        if (!scan_en) m_ptr = 0;
    endfunction

    task automatic compare_model();
        chk("mdl_data", data_out, m_data);
        chk("mdl_ch", ch_out, m_ch);
        chk("mdl_valid", data_valid, m_v);
        chk("mdl_selerr", sel_err, m_e);
        chk("mdl_sticky", err_sticky, m_s);
        chk("mdl_cnt", lock_cnt, 64'(m_cnt));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    // Leaves the bench at the negedge following the capture edge, strobe still high.
    task automatic strobe(input bit scan, input logic [SEL_W-1:0] sel, input bit clr);
        scan_en   = scan;
        selector  = sel;
        err_clr   = 1'b0;
        data_lock = 1'b0;
        repeat (LAT + 2) cycle();
        data_lock = 1'b1;
        err_clr   = clr;
        repeat (LAT + 1) cycle();
    endtask

    typedef struct {
        bit               scan;
        logic [SEL_W-1:0] sel;
        bit               clr;
        int               hold;
        logic [WIDTH-1:0] d;
        logic [SEL_W-1:0] ch;
        bit               v;
        bit               e;
        bit               s;
        int               cnt;
    } vec_t;

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{1'b0, 8'd0, 1'b0, 1,  16'h1111, 8'd0, 1'b1, 1'b0, 1'b0, 1};
        tbl[1]  = '{1'b0, 8'd2, 1'b0, 10, 16'h3333, 8'd2, 1'b1, 1'b0, 1'b0, 2};
        tbl[2]  = '{1'b0, 8'd7, 1'b0, 1,  16'h3333, 8'd2, 1'b0, 1'b1, 1'b1, 2};
        tbl[3]  = '{1'b0, 8'd9, 1'b1, 1,  16'h3333, 8'd2, 1'b0, 1'b1, 1'b1, 2};
        tbl[4]  = '{1'b0, 8'd1, 1'b1, 1,  16'h2222, 8'd1, 1'b1, 1'b0, 1'b0, 3};
        tbl[5]  = '{1'b0, 8'd3, 1'b0, 1,  16'h4444, 8'd3, 1'b1, 1'b0, 1'b0, 4};
        tbl[6]  = '{1'b0, 8'd4, 1'b0, 1,  16'h4444, 8'd3, 1'b0, 1'b1, 1'b1, 4};
        tbl[7]  = '{1'b1, 8'd7, 1'b0, 1,  16'h1111, 8'd0, 1'b1, 1'b0, 1'b1, 5};
        tbl[8]  = '{1'b1, 8'd7, 1'b0, 1,  16'h2222, 8'd1, 1'b1, 1'b0, 1'b1, 6};
        tbl[9]  = '{1'b1, 8'd7, 1'b0, 1,  16'h3333, 8'd2, 1'b1, 1'b0, 1'b1, 7};
        tbl[10] = '{1'b1, 8'd7, 1'b0, 1,  16'h4444, 8'd3, 1'b1, 1'b0, 1'b1, 8};
        tbl[11] = '{1'b1, 8'd7, 1'b0, 1,  16'h1111, 8'd0, 1'b1, 1'b0, 1'b1, 9};

        reset     = 1'b1;
        data_lock = 1'b1;
        scan_en   = 1'b0;
        selector  = '0;
        err_clr   = 1'b0;
        data_in   = 64'h4444_3333_2222_1111;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_data", data_out, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_cnt", lock_cnt, 0);
        reset = 1'b0;

        // Strobe held high across reset release must not capture.
        repeat (5) cycle();
        chk("held_valid", data_valid, 0);
        chk("held_data", data_out, 0);
        chk("held_cnt", lock_cnt, 0);

        foreach (tbl[i]) begin
            strobe(tbl[i].scan, tbl[i].sel, tbl[i].clr);
            chk($sformatf("tbl%0d_data", i), data_out, tbl[i].d);
            chk($sformatf("tbl%0d_ch", i), ch_out, tbl[i].ch);
            chk($sformatf("tbl%0d_valid", i), data_valid, tbl[i].v);
            chk($sformatf("tbl%0d_selerr", i), sel_err, tbl[i].e);
            chk($sformatf("tbl%0d_sticky", i), err_sticky, tbl[i].s);
            chk($sformatf("tbl%0d_cnt", i), lock_cnt, 64'(tbl[i].cnt));
            err_clr = 1'b0;
            repeat (tbl[i].hold) cycle();
            chk($sformatf("tbl%0d_hold_valid", i), data_valid, 0);
            chk($sformatf("tbl%0d_hold_cnt", i), lock_cnt, 64'(tbl[i].cnt));
        end

        // Clear without a coincident error.
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        chk("clr_alone_sticky", err_sticky, 0);

        // One cycle of direct mode restarts the scan at channel 0.
        scan_en = 1'b0;
        cycle();
        strobe(1'b1, 8'd7, 1'b0);
        chk("rescan_ch", ch_out, 0);
        chk("rescan_data", data_out, 16'h1111);
        chk("rescan_valid", data_valid, 1);
        chk("rescan_cnt", lock_cnt, 10);

        // Asynchronous reset while the capture pulse is still high.
        #2 reset = 1'b1;
        #1;
        chk("arst_data", data_out, 0);
        chk("arst_ch", ch_out, 0);
        chk("arst_valid", data_valid, 0);
        chk("arst_cnt", lock_cnt, 0);
        model_reset();
        cycle();
        reset = 1'b0;
        data_lock = 1'b0;
        cycle();

        // Counter wrap: 17 good captures on a 4-bit counter.
        for (int i = 0; i < 17; i++) begin
            strobe(1'b0, SEL_W'(i % CHANNELS), 1'b0);
        end
        chk("wrap_cnt", lock_cnt, 1);
        chk("wrap_data", data_out, 16'h1111);

        // Randomized run against the model.
        for (int n = 0; n < 600; n++) begin
            data_in = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) data_lock = ~data_lock;
            if ($urandom_range(0, 15) == 0) scan_en = ~scan_en;
            selector = SEL_W'($urandom_range(0, 6));
            err_clr  = ($urandom_range(0, 7) == 0);
            reset    = ($urandom_range(0, 99) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
